// File: rtl/timer_pkg.sv
// Shared timer constants and counter-operation encoding.
// Used by the register file, timer control and counter stage.
package timer_pkg;

  localparam int CNT_W = 64;
  localparam int DATA_W = 32;
  localparam logic [CNT_W-1:0] CMP_RST = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_CLR,
    CNT_LOAD,
    CNT_INC
  } cnt_op_e;

endpackage

// File: rtl/timer_counter_if.sv
// Register-file bus between timer registers and counter stage.
// master = register file, slave = counter/compare stage.
interface timer_counter_if #(
  parameter int CNT_W = 64,
  parameter int DATA_W = 32
);

  logic              wr_cnt_lo;
  logic              wr_cnt_hi;
  logic              wr_cmp_lo;
  logic              wr_cmp_hi;
  logic [DATA_W-1:0] wdata;
  logic              int_en;
  logic              int_clr;
  logic              ovf_clr;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  cmp_val;
  logic              int_st;
  logic              ovf_st;

  modport master (
    output wr_cnt_lo, wr_cnt_hi,
    output wr_cmp_lo, wr_cmp_hi,
    output wdata, int_en,
    output int_clr, ovf_clr,
    input  cnt_val, cmp_val,
    input  int_st, ovf_st
  );

  modport slave (
    input  wr_cnt_lo, wr_cnt_hi,
    input  wr_cmp_lo, wr_cmp_hi,
    input  wdata, int_en,
    input  int_clr, ovf_clr,
    output cnt_val, cmp_val,
    output int_st, ovf_st
  );

endinterface

// File: rtl/timer_cnt_reg.sv
// 64-bit timer count: half-write load, increment,
// enable falling-edge clear and wrap indication.
module timer_cnt_reg
  import timer_pkg::*;
#(
  parameter int CNT_W = timer_pkg::CNT_W,
  parameter int DATA_W = timer_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timer_en_i,
  input  logic              cnt_en_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             en_q;
  logic             fall;
  logic             inc;
  cnt_op_e          op;

  assign fall = en_q & ~timer_en_i;
  assign inc  = timer_en_i & cnt_en_i;

  // Pick the counter operation: edge clear > write > increment.
  always_comb begin
    op = CNT_HOLD;
    priority case (1'b1)
      fall:                op = CNT_CLR;
      (wr_lo_i | wr_hi_i): op = CNT_LOAD;
      inc:                 op = CNT_INC;
      default:             op = CNT_HOLD;
    endcase
  end

  // Next count; wrap flags the all-ones increment so status
  // lands together with the count returning to zero.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    unique case (op)
      CNT_CLR: cnt_d = '0;
      CNT_LOAD: begin
        if (wr_lo_i) cnt_d[DATA_W-1:0] = wdata_i;
        if (wr_hi_i) cnt_d[CNT_W-1:DATA_W] = wdata_i;
      end
      CNT_INC: begin
        cnt_d  = cnt_q + CNT_W'(1);
        wrap_o = &cnt_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Count and enable-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= timer_en_i;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/timer_counter.sv
// Timer counter/compare stage: count, compare register,
// sticky match/wrap status and level interrupt.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = timer_pkg::CNT_W,
  parameter int DATA_W = timer_pkg::DATA_W,
  parameter logic [CNT_W-1:0] CMP_RST = timer_pkg::CMP_RST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         timer_en,
  input  logic         cnt_en,
  timer_counter_if.slave bus,
  output logic         tim_int
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cmp_q;
  logic [CNT_W-1:0] cmp_d;
  logic             int_st_q;
  logic             int_st_d;
  logic             ovf_st_q;
  logic             ovf_st_d;
  logic             wrap;
  logic             match;

  timer_cnt_reg #(
    .CNT_W (CNT_W),
    .DATA_W(DATA_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .timer_en_i(timer_en),
    .cnt_en_i  (cnt_en),
    .wr_lo_i   (bus.wr_cnt_lo),
    .wr_hi_i   (bus.wr_cnt_hi),
    .wdata_i   (bus.wdata),
    .cnt_o     (cnt_q),
    .wrap_o    (wrap)
  );

  assign match = (cnt_q == cmp_q);

  // Compare half-writes and sticky status; set beats clear.
  always_comb begin
    cmp_d = cmp_q;
    if (bus.wr_cmp_lo) cmp_d[DATA_W-1:0] = bus.wdata;
    if (bus.wr_cmp_hi) cmp_d[CNT_W-1:DATA_W] = bus.wdata;
    int_st_d = match | (int_st_q & ~bus.int_clr);
    ovf_st_d = wrap | (ovf_st_q & ~bus.ovf_clr);
  end

  // Compare and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q    <= CMP_RST;
      int_st_q <= 1'b0;
      ovf_st_q <= 1'b0;
    end else begin
      cmp_q    <= cmp_d;
      int_st_q <= int_st_d;
      ovf_st_q <= ovf_st_d;
    end
  end

  assign bus.cnt_val = cnt_q;
  assign bus.cmp_val = cmp_q;
  assign bus.int_st  = int_st_q;
  assign bus.ovf_st  = ovf_st_q;
  assign tim_int     = int_st_q & bus.int_en;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_timer_counter;

  logic clk = 1'b0;
  logic rst;
  logic timer_en;
  logic cnt_en;
  logic tim_int;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [63:0] ONES = {64{1'b1}};

  timer_counter_if #(.CNT_W(64), .DATA_W(32)) bus ();

  timer_counter dut (
    .clk     (clk),
    .rst     (rst),
    .timer_en(timer_en),
    .cnt_en  (cnt_en),
    .bus     (bus),
    .tim_int (tim_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic cl, input logic ch,
                    input logic ml, input logic mh,
                    input logic [31:0] d);
    bus.wr_cnt_lo = cl;
    bus.wr_cnt_hi = ch;
    bus.wr_cmp_lo = ml;
    bus.wr_cmp_hi = mh;
    bus.wdata     = d;
    tick();
    bus.wr_cnt_lo = 1'b0;
    bus.wr_cnt_hi = 1'b0;
    bus.wr_cmp_lo = 1'b0;
    bus.wr_cmp_hi = 1'b0;
    bus.wdata     = '0;
  endtask

  initial begin
    rst = 1'b1;
    timer_en = 1'b0;
    cnt_en = 1'b0;
    bus.wr_cnt_lo = 1'b0;
    bus.wr_cnt_hi = 1'b0;
    bus.wr_cmp_lo = 1'b0;
    bus.wr_cmp_hi = 1'b0;
    bus.wdata = '0;
    bus.int_en = 1'b0;
    bus.int_clr = 1'b0;
    bus.ovf_clr = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_cnt", bus.cnt_val, 64'd0);
    chk("rst_cmp", bus.cmp_val, ONES);
    chk("rst_int", 64'(bus.int_st), 64'd0);
    chk("rst_ovf", 64'(bus.ovf_st), 64'd0);
    chk("rst_tim", 64'(tim_int), 64'd0);

    // free count for 10 cycles
    timer_en = 1'b1;
    cnt_en = 1'b1;
    tick(10);
    cnt_en = 1'b0;
    chk("cnt10", bus.cnt_val, 64'd10);
    chk("cnt10_int", 64'(bus.int_st), 64'd0);
    chk("cnt10_ovf", 64'(bus.ovf_st), 64'd0);
    chk("cnt10_tim", 64'(tim_int), 64'd0);

    // compare=5, count restart from 0 in the same write cycle
    wr(1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    wr(1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
    bus.int_en = 1'b1;
    chk("cmp5", bus.cmp_val, 64'd5);
    chk("cnt_clr_wr", bus.cnt_val, 64'd0);
    cnt_en = 1'b1;
    tick(5);
    cnt_en = 1'b0;
    chk("at5", bus.cnt_val, 64'd5);
    tick();
    chk("match_int", 64'(bus.int_st), 64'd1);
    chk("match_tim", 64'(tim_int), 64'd1);
    bus.int_clr = 1'b1;
    tick();
    bus.int_clr = 1'b0;
    chk("clr_on_match", 64'(bus.int_st), 64'd1);
    cnt_en = 1'b1;
    tick(2);
    cnt_en = 1'b0;
    chk("at7", bus.cnt_val, 64'd7);
    chk("int_sticky", 64'(bus.int_st), 64'd1);
    bus.int_clr = 1'b1;
    tick();
    bus.int_clr = 1'b0;
    chk("clr_int", 64'(bus.int_st), 64'd0);
    chk("clr_tim", 64'(tim_int), 64'd0);

    // wrap
    wr(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    wr(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("wr_near_wrap", bus.cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
    cnt_en = 1'b1;
    tick();
    cnt_en = 1'b0;
    chk("all_ones", bus.cnt_val, ONES);
    chk("no_ovf_yet", 64'(bus.ovf_st), 64'd0);
    cnt_en = 1'b1;
    tick();
    cnt_en = 1'b0;
    chk("wrap_cnt", bus.cnt_val, 64'd0);
    chk("wrap_ovf", 64'(bus.ovf_st), 64'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 64'(bus.ovf_st), 64'd0);
    wr(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    cnt_en = 1'b1;
    bus.ovf_clr = 1'b1;
    tick();
    cnt_en = 1'b0;
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", 64'(bus.ovf_st), 64'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr2", 64'(bus.ovf_st), 64'd0);

    // divider/halt pattern
    for (int i = 0; i < 6; i++) begin
      cnt_en = (i % 2 == 0);
      tick();
    end
    cnt_en = 1'b0;
    chk("toggle3", bus.cnt_val, 64'd3);
    cnt_en = 1'b1;
    wr(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    cnt_en = 1'b0;
    chk("wr_beats_inc", bus.cnt_val, 64'h100);
    wr(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
    chk("hi_only", bus.cnt_val, 64'h1_0000_0100);

    // falling edge of timer_en
    wr(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    wr(1'b1, 1'b0, 1'b0, 1'b0, 32'h1F);
    cnt_en = 1'b1;
    tick();
    chk("at20", bus.cnt_val, 64'h20);
    timer_en = 1'b0;
    tick();
    chk("fall_clr", bus.cnt_val, 64'd0);
    chk("fall_no_ovf", 64'(bus.ovf_st), 64'd0);
    tick();
    chk("dis_hold", bus.cnt_val, 64'd0);
    timer_en = 1'b1;
    tick(3);
    chk("resume", bus.cnt_val, 64'd3);
    tick(3);
    chk("int_pre_rst", 64'(bus.int_st), 64'd1);

    // reset mid-count overrides a compare write
    rst = 1'b1;
    bus.wr_cmp_lo = 1'b1;
    bus.wdata = 32'd7;
    tick();
    rst = 1'b0;
    bus.wr_cmp_lo = 1'b0;
    bus.wdata = '0;
    cnt_en = 1'b0;
    chk("mrst_cnt", bus.cnt_val, 64'd0);
    chk("mrst_cmp", bus.cmp_val, ONES);
    chk("mrst_int", 64'(bus.int_st), 64'd0);
    chk("mrst_ovf", 64'(bus.ovf_st), 64'd0);
    chk("mrst_tim", 64'(tim_int), 64'd0);

    // interrupt masking
    bus.int_en = 1'b0;
    wr(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    tick();
    chk("mask_int", 64'(bus.int_st), 64'd1);
    chk("mask_tim", 64'(tim_int), 64'd0);
    bus.int_en = 1'b1;
    #1;
    chk("unmask_tim", 64'(tim_int), 64'd1);
    bus.int_en = 1'b0;
    #1;
    chk("remask_tim", 64'(tim_int), 64'd0);
    chk("remask_int", 64'(bus.int_st), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counter/compare stage directly downstream of the timer control block.
- Consumes its per-cycle `cnt_en` qualifier and maintains the 64-bit timer count.
- Compares the count against a software-programmed 64-bit compare value and produces sticky compare and overflow status plus a level interrupt.
- Register-file writes arrive as per-half write strobes with 32-bit data.

Parameters:
- CNT_W, 64: counter and compare width. Must equal 2*DATA_W.
- DATA_W, 32: software write-data width.
- CMP_RST, {CNT_W{1'b1}}: reset value of the compare register.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous active-high reset; one clock; polarity and synchronicity fixed
- timer_en  in  1  timer enable from control register
- cnt_en  in  1  increment qualifier from timer control; already gated by divider and debug halt
- wr_cnt_lo  in  1  write strobe, cnt_val[31:0]
- wr_cnt_hi  in  1  write strobe, cnt_val[63:32]
- wr_cmp_lo  in  1  write strobe, cmp_val[31:0]
- wr_cmp_hi  in  1  write strobe, cmp_val[63:32]
- wdata  in  DATA_W  write data for all strobes
- int_en  in  1  interrupt enable
- int_clr  in  1  one-cycle W1C pulse for int_st
- ovf_clr  in  1  one-cycle W1C pulse for ovf_st
- cnt_val  out  CNT_W  current count
- cmp_val  out  CNT_W  current compare value
- int_st  out  1  sticky compare-match status
- ovf_st  out  1  sticky wrap status
- tim_int  out  1  interrupt output = int_st & int_en

Behaviour:
- Reset (rst=1 at posedge): cnt_val=0, cmp_val=CMP_RST, int_st=0, ovf_st=0, hence tim_int=0. Reset overrides every other input that cycle.
- Enable edge tracking: timer_en is registered as en_q (reset value 0).
- Counter update priority, evaluated each cycle, highest first:
  1. Reset.
  2. Falling edge of timer_en (en_q=1, timer_en=0): cnt_val clears to 0.
  3. Software write: wr_cnt_lo and/or wr_cnt_hi load the addressed half(s) from wdata. The unwritten half holds. No increment that cycle.
  4. Increment: if timer_en & cnt_en, cnt_val <= cnt_val+1, modulo 2^CNT_W.
  5. Otherwise hold.
- Increment latency: cnt_en high in cycle N gives the new value visible in cycle N+1. No combinational path from cnt_en to cnt_val.
- Debug halt: cnt_en is already low while halted, so the count holds. Writes are still accepted during halt.
- Compare register: wr_cmp_lo/wr_cmp_hi load the addressed half the next cycle. Compare writes are independent of counter writes; both may occur in the same cycle.
- Match: match = (cnt_val == cmp_val), both registered values, full 64-bit equality. Match is evaluated regardless of timer_en.
- int_st:
  - Sets on any cycle where match=1.
  - int_clr clears it only when match=0 that cycle; set beats clear.
  - Stays 1 while the count remains equal to the compare value.
- ovf_st:
  - Sets in the cycle the increment wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 (status visible together with cnt_val=0).
  - Set beats ovf_clr.
  - A software write of all-ones followed by an increment also wraps and sets it.
  - A falling-edge clear or a software write of 0 does not set it.
- tim_int: combinational AND of registered int_st and int_en. Deasserting int_en masks the output but does not clear int_st.
- Half-write boundary: a lo-only write never carries into the hi half. Software is responsible for coherent 64-bit programming.

Decomposition:
- Package timer_pkg holds CNT_W, DATA_W and CMP_RST, shared with the register file and timer control.
- One natural sub-module: timer_cnt_reg. It covers the 64-bit register with half-write load, increment, edge clear and wrap flag.
- Compare, status and interrupt logic stay in timer_counter.

Test Plan:
- rst high 1 cycle, then timer_en=1, cnt_en=1 for 10 cycles -> cnt_val=10, int_st=0, ovf_st=0, tim_int=0.
- wr_cmp_lo wdata=5, wr_cmp_hi wdata=0, int_en=1, counting from 0 -> int_st and tim_int rise the cycle cnt_val==5. int_clr while cnt_val==5 keeps int_st=1; int_clr at cnt_val=7 gives int_st=0.
- Write cnt hi=0xFFFF_FFFF and lo=0xFFFF_FFFE, cnt_en pulses -> cnt_val=..FFFF, then 0 with ovf_st=1. ovf_clr gives ovf_st=0.
- cnt_en toggling 1-0-1 (divider/halt pattern) for 6 cycles -> cnt_val advances exactly 3. Simultaneous wr_cnt_lo=0x100 and cnt_en=1 -> cnt_val[31:0]=0x100, no +1.
- Counting at cnt_val=0x20, timer_en 1->0 -> cnt_val=0 next cycle. Re-enable resumes from 0. rst mid-count -> all outputs return to reset values, cmp_val=all ones.
- int_st=1 with int_en=0 -> tim_int=0. Setting int_en=1 -> tim_int=1 the same cycle.
